// File: rtl/ex_operand_stage_if.sv
// Decode/execute handshake, operand and forwarding bus for ex_operand_stage.
// master: decode/pipeline side driving the stage; slave: the stage itself.
interface ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned CONW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_sel_a;
  logic            in_sel_b;
  logic [CONW-1:0] in_alu_con;
  logic [REGW-1:0] in_rd;
  logic            in_reg_wr;
  logic            flush;
  logic            mem_wr;
  logic [REGW-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_wr;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [CONW-1:0] alu_con;
  logic [REGW-1:0] out_rd;
  logic            out_reg_wr;

  modport master (
    output in_valid, in_rs1_data, in_rs2_data, in_rs1, in_rs2, in_pc, in_imm,
           in_sel_a, in_sel_b, in_alu_con, in_rd, in_reg_wr, flush,
           mem_wr, mem_rd, mem_data, wb_wr, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_con, out_rd, out_reg_wr
  );

  modport slave (
    input  in_valid, in_rs1_data, in_rs2_data, in_rs1, in_rs2, in_pc, in_imm,
           in_sel_a, in_sel_b, in_alu_con, in_rd, in_reg_wr, flush,
           mem_wr, mem_rd, mem_data, wb_wr, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_con, out_rd, out_reg_wr
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Decode-to-execute operand stage: two-entry skid buffer, WB refresh of held operands, ALU drive.
// Define EX_OPERAND_FWD_EN to forward EX/MEM and MEM/WB results onto the ALU operands.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned CONW = 4
) (
  input logic                clk,
  input logic                rst,
  ex_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            sel_a;
    logic            sel_b;
    logic [CONW-1:0] alu_con;
    logic [REGW-1:0] rd;
    logic            reg_wr;
  } entry_t;

  entry_t          r_main;
  entry_t          r_skid;
  entry_t          w_main_d;
  entry_t          w_skid_d;
  entry_t          w_in_entry;
  logic            w_fire_in;
  logic            w_fire_out;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // A write to a matching nonzero index lands in the operand, write-first.
  function automatic entry_t refresh(entry_t e, logic wr, logic [REGW-1:0] rd,
                                     logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (wr && (rd != '0) && (rd == e.rs1)) r.rs1_data = data;
    if (wr && (rd != '0) && (rd == e.rs2)) r.rs2_data = data;
    return r;
  endfunction

  assign bus.in_ready = ~r_skid.valid;
  assign bus.out_valid = r_main.valid;
  assign w_fire_in = bus.in_valid & ~r_skid.valid;
  assign w_fire_out = r_main.valid & bus.out_ready;

  always_comb begin
    w_in_entry          = '0;
    w_in_entry.valid    = 1'b1;
    w_in_entry.rs1_data = bus.in_rs1_data;
    w_in_entry.rs2_data = bus.in_rs2_data;
    w_in_entry.rs1      = bus.in_rs1;
    w_in_entry.rs2      = bus.in_rs2;
    w_in_entry.pc       = bus.in_pc;
    w_in_entry.imm      = bus.in_imm;
    w_in_entry.sel_a    = bus.in_sel_a;
    w_in_entry.sel_b    = bus.in_sel_b;
    w_in_entry.alu_con  = bus.in_alu_con;
    w_in_entry.rd       = bus.in_rd;
    w_in_entry.reg_wr   = bus.in_reg_wr;
  end

  always_comb begin
    w_main_d = refresh(r_main, bus.wb_wr, bus.wb_rd, bus.wb_data);
    w_skid_d = refresh(r_skid, bus.wb_wr, bus.wb_rd, bus.wb_data);
    if (w_fire_out || !r_main.valid) begin
      if (r_skid.valid) begin
        // in_ready is low here, so no input competes with the skid entry.
        w_main_d       = w_skid_d;
        w_skid_d.valid = 1'b0;
      end else if (w_fire_in) begin
        w_main_d = refresh(w_in_entry, bus.wb_wr, bus.wb_rd, bus.wb_data);
      end else begin
        w_main_d.valid = 1'b0;
      end
    end else if (w_fire_in) begin
      w_skid_d = refresh(w_in_entry, bus.wb_wr, bus.wb_rd, bus.wb_data);
    end
    if (bus.flush) begin
      w_main_d.valid = 1'b0;
      w_skid_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      r_main <= w_main_d;
      r_skid <= w_skid_d;
    end
  end

`ifdef EX_OPERAND_FWD_EN
  always_comb begin
    w_rs1_fwd = r_main.rs1_data;
    w_rs2_fwd = r_main.rs2_data;
    if (bus.mem_wr && (bus.mem_rd != '0) && (bus.mem_rd == r_main.rs1)) begin
      w_rs1_fwd = bus.mem_data;
    end else if (bus.wb_wr && (bus.wb_rd != '0) && (bus.wb_rd == r_main.rs1)) begin
      w_rs1_fwd = bus.wb_data;
    end
    if (bus.mem_wr && (bus.mem_rd != '0) && (bus.mem_rd == r_main.rs2)) begin
      w_rs2_fwd = bus.mem_data;
    end else if (bus.wb_wr && (bus.wb_rd != '0) && (bus.wb_rd == r_main.rs2)) begin
      w_rs2_fwd = bus.wb_data;
    end
  end
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{bus.mem_wr, bus.mem_rd, bus.mem_data};
  assign w_rs1_fwd = r_main.rs1_data;
  assign w_rs2_fwd = r_main.rs2_data;
`endif

  assign bus.alu_a      = r_main.sel_a ? r_main.pc : w_rs1_fwd;
  assign bus.alu_b      = r_main.sel_b ? r_main.imm : w_rs2_fwd;
  assign bus.alu_con    = r_main.alu_con;
  assign bus.out_rd     = r_main.rd;
  assign bus.out_reg_wr = r_main.valid & r_main.reg_wr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: pass-through vector table plus directed
// sequences for skid fill/drain, forwarding, WB refresh, flush and async reset.
module tb_ex_operand_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_operand_stage_if #(.XLEN(32), .REGW(5), .CONW(4)) bus ();

  ex_operand_stage #(.XLEN(32), .REGW(5), .CONW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        sel_a;
    logic        sel_b;
    logic [3:0]  con;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        wb_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] rs1d, input logic [31:0] rs2d,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic sa, input logic sb, input logic [3:0] con,
                          input logic [4:0] rd, input logic wr);
    bus.in_valid    = 1'b1;
    bus.in_rs1_data = rs1d;
    bus.in_rs2_data = rs2d;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
    bus.in_sel_a    = sa;
    bus.in_sel_b    = sb;
    bus.in_alu_con  = con;
    bus.in_rd       = rd;
    bus.in_reg_wr   = wr;
  endtask

  task automatic idle_side();
    bus.mem_wr  = 1'b0;
    bus.mem_rd  = '0;
    bus.mem_data = '0;
    bus.wb_wr   = 1'b0;
    bus.wb_rd   = '0;
    bus.wb_data = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle_side();

    vecs[0] = '{32'd10, 32'd16, 5'd1, 5'd2, 32'h100, 32'h4, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1,
                1'b0, 5'd0, 32'h0, 32'd10, 32'd16};
    vecs[1] = '{32'd5, 32'd6, 5'd1, 5'd2, 32'h1000, 32'hFFFF_FFFC, 1'b1, 1'b1, 4'd5, 5'd7, 1'b0,
                1'b0, 5'd0, 32'h0, 32'h1000, 32'hFFFF_FFFC};
    vecs[2] = '{32'h1, 32'h33, 5'd3, 5'd4, 32'h2000, 32'h8, 1'b1, 1'b0, 4'd14, 5'd31, 1'b1,
                1'b0, 5'd0, 32'h0, 32'h2000, 32'h33};
    vecs[3] = '{32'hDEAD_BEEF, 32'h2, 5'd6, 5'd8, 32'h3000, 32'h7FF, 1'b0, 1'b1, 4'd15, 5'd1, 1'b1,
                1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h7FF};
    vecs[4] = '{32'h11, 32'h44, 5'd9, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0, 4'd2, 5'd9, 1'b1,
                1'b1, 5'd9, 32'h99, 32'h99, 32'h44};
    vecs[5] = '{32'h55, 32'h66, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3, 5'd0, 1'b1,
                1'b1, 5'd0, 32'h77, 32'h55, 32'h66};
    vecs[6] = '{32'h12, 32'h13, 5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4, 5'd2, 1'b0,
                1'b0, 5'd9, 32'h99, 32'h12, 32'h13};

    #12;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_con", {28'b0, bus.alu_con}, 32'd0);
    chk("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("rst_out_reg_wr", {31'b0, bus.out_reg_wr}, 32'd0);
    rst = 1'b0;
    tick();

    // Pass-through at one op per cycle.
    for (int i = 0; i < 7; i++) begin
      drive_op(vecs[i].rs1_data, vecs[i].rs2_data, vecs[i].rs1, vecs[i].rs2, vecs[i].pc,
               vecs[i].imm, vecs[i].sel_a, vecs[i].sel_b, vecs[i].con, vecs[i].rd,
               vecs[i].reg_wr);
      bus.wb_wr   = vecs[i].wb_wr;
      bus.wb_rd   = vecs[i].wb_rd;
      bus.wb_data = vecs[i].wb_data;
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].exp_b);
      chk($sformatf("v%0d_alu_con", i), {28'b0, bus.alu_con}, {28'b0, vecs[i].con});
      chk($sformatf("v%0d_out_rd", i), {27'b0, bus.out_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_reg_wr", i), {31'b0, bus.out_reg_wr}, {31'b0, vecs[i].reg_wr});
    end
    bus.in_valid = 1'b0;
    idle_side();
    tick();
    chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("drain_reg_wr", {31'b0, bus.out_reg_wr}, 32'd0);

    // Skid fill with a held head, then ordered drain.
    bus.out_ready = 1'b0;
    drive_op(32'hA1, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd1, 5'd1, 1'b1);
    tick();
    chk("skid_a_head", bus.alu_a, 32'hA1);
    chk("skid_a_ready", {31'b0, bus.in_ready}, 32'd1);
    drive_op(32'hB2, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd2, 5'd2, 1'b1);
    tick();
    chk("skid_b_held", bus.alu_a, 32'hA1);
    chk("skid_b_ready", {31'b0, bus.in_ready}, 32'd0);
    drive_op(32'hC3, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd3, 5'd3, 1'b1);
    tick();
    chk("skid_c_held", bus.alu_a, 32'hA1);
    chk("skid_c_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("skid_c_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("drain_b", bus.alu_a, 32'hB2);
    chk("drain_b_con", {28'b0, bus.alu_con}, 32'd2);
    chk("drain_b_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("drain_c", bus.alu_a, 32'hC3);
    chk("drain_c_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_empty", {31'b0, bus.out_valid}, 32'd0);

    // Forwarding priority on a held head.
    bus.out_ready = 1'b0;
    drive_op(32'h11, 32'h0, 5'd5, 5'd6, 32'h500, 0, 0, 0, 4'd0, 5'd1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.mem_wr   = 1'b1;
    bus.mem_rd   = 5'd5;
    bus.mem_data = 32'hAA;
    bus.wb_wr    = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hBB;
    #1;
`ifdef EX_OPERAND_FWD_EN
    chk("fwd_mem", bus.alu_a, 32'hAA);
`else
    chk("fwd_mem", bus.alu_a, 32'h11);
`endif
    bus.mem_wr = 1'b0;
    #1;
`ifdef EX_OPERAND_FWD_EN
    chk("fwd_wb", bus.alu_a, 32'hBB);
`else
    chk("fwd_wb", bus.alu_a, 32'h11);
`endif
    tick();
    bus.wb_wr = 1'b0;
    #1;
    chk("refresh_rs1", bus.alu_a, 32'hBB);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive_op(32'h22, 32'h0, 5'd0, 5'd6, 32'h600, 0, 0, 0, 4'd0, 5'd1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.mem_wr   = 1'b1;
    bus.mem_rd   = 5'd0;
    bus.wb_wr    = 1'b1;
    bus.wb_rd    = 5'd0;
    #1;
    chk("fwd_idx0", bus.alu_a, 32'h22);
    tick();
    chk("refresh_idx0", bus.alu_a, 32'h22);
    idle_side();
    bus.out_ready = 1'b1;
    tick();

    // WB refresh while held, then release.
    bus.out_ready = 1'b0;
    drive_op(32'h0, 32'h70, 5'd1, 5'd7, 0, 0, 0, 0, 4'd6, 5'd4, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_wr    = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'hFFFF_FFF6;
    tick();
    bus.wb_wr = 1'b0;
    #1;
    chk("refresh_rs2_held", bus.alu_b, 32'hFFFF_FFF6);
    bus.out_ready = 1'b1;
    #1;
    chk("refresh_rs2_rel", bus.alu_b, 32'hFFFF_FFF6);
    tick();
    chk("refresh_drained", {31'b0, bus.out_valid}, 32'd0);
    idle_side();

    // Flush with both entries full and a competing input.
    bus.out_ready = 1'b0;
    drive_op(32'hE1, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd0, 5'd1, 1'b1);
    tick();
    drive_op(32'hE2, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd0, 5'd1, 1'b1);
    tick();
    chk("flush_full", {31'b0, bus.in_ready}, 32'd0);
    drive_op(32'hD4, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd0, 5'd1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_reg_wr", {31'b0, bus.out_reg_wr}, 32'd0);
    tick();
    chk("flush_dropped", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset between clock edges.
    bus.out_ready = 1'b1;
    drive_op(32'hF0, 0, 5'd1, 5'd2, 0, 0, 0, 0, 4'd9, 5'd5, 1'b1);
    tick();
    chk("pre_rst_reg_wr", {31'b0, bus.out_reg_wr}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async_rst_reg_wr", {31'b0, bus.out_reg_wr}, 32'd0);
    chk("async_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("async_rst_alu_a", bus.alu_a, 32'd0);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
